shift_word_assembler: RTL and testbench

- Upstream feeder for the right-shift stage: collects a serial bit stream into WIDTH-bit parallel words.
- Completed words go into a 2-entry output buffer with valid/ready handshake; the shifter's din is driven from word_out.
- Supports MSB-first or LSB-first bit order, and a flush that zero-pads and emits a partial word.

---
 rtl/shift_word_assembler.sv | 149 ++++++++++++++
 tb/tb_shift_word_assembler.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/shift_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : shift_word_assembler
// Description : Collects a serial bit stream into WIDTH-bit words and queues
//               them in a 2-entry valid/ready output buffer. Supports MSB- or
//               LSB-first ordering and a flush that zero-pads a partial word.
//               Optional macro SHIFT_ASM_PARITY_EN adds the word_par output
//               (even parity of the head word, stored per entry).
// Revision    : 1.0 - initial release
// ============================================================================
module shift_word_assembler #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             bit_in,
    input  logic             bit_valid,
    output logic             bit_ready,
    input  logic             flush,
    output logic [WIDTH-1:0] word_out,
    output logic             word_partial,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [1:0]       fill_level
`ifdef SHIFT_ASM_PARITY_EN
    ,
    output logic             word_par
`endif
);

    localparam int             c_CW    = $clog2(WIDTH + 1);
    localparam logic [c_CW-1:0] c_ONE  = 1;
    localparam logic [c_CW-1:0] c_LAST = c_CW'(WIDTH - 1);
    localparam logic [c_CW-1:0] c_W    = c_CW'(WIDTH);

    logic [c_CW-1:0]  r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_mem  [2];
    logic             r_part [2];
    logic             r_wptr;
    logic             r_rptr;
    logic [1:0]       r_fill;
`ifdef SHIFT_ASM_PARITY_EN
    logic             r_par  [2];
`endif

    logic             w_accept;
    logic [WIDTH-1:0] w_acc_shift;
    logic [WIDTH-1:0] w_acc_incl;
    logic [c_CW-1:0]  w_n;
    logic [c_CW-1:0]  w_shamt;
    logic             w_full;
    logic             w_flush;
    logic             w_push;
    logic             w_pop;
    logic [WIDTH-1:0] w_push_word;

    // Ready depends only on occupancy so there is no path from word_ready
    assign bit_ready = rst & (r_fill != 2'd2);
    assign w_accept  = bit_valid & bit_ready;
    assign w_pop     = (r_fill != 2'd0) & word_ready;

    // Accumulator next value, word completion and flush padding
    always_comb begin
        w_acc_shift = r_acc;
        if (MSB_FIRST != 0) begin
            w_acc_shift = {r_acc[WIDTH-2:0], bit_in};
        end else begin
            w_acc_shift = {bit_in, r_acc[WIDTH-1:1]};
        end
        w_acc_incl = w_accept ? w_acc_shift : r_acc;
        w_n        = r_cnt + {{(c_CW-1){1'b0}}, w_accept};
        w_full     = w_accept & (r_cnt == c_LAST);
        // A flush that fills the word is just a normal full push
        w_flush    = flush & bit_ready & (w_n != '0) & ~w_full;
        w_push     = w_full | w_flush;
        w_shamt    = c_W - w_n;
        w_push_word = w_acc_incl;
        if (w_flush) begin
            if (MSB_FIRST != 0) begin
                w_push_word = w_acc_incl << w_shamt;
            end else begin
                w_push_word = w_acc_incl >> w_shamt;
            end
        end
    end

    // Head of buffer is forced to zero when the buffer is empty
    always_comb begin
        word_valid   = (r_fill != 2'd0);
        word_out     = word_valid ? r_mem[r_rptr]  : '0;
        word_partial = word_valid ? r_part[r_rptr] : 1'b0;
        fill_level   = r_fill;
`ifdef SHIFT_ASM_PARITY_EN
        word_par     = word_valid ? r_par[r_rptr]  : 1'b0;
`endif
    end

    // Bit counter and accumulator; cleared whenever a word is pushed
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_push) begin
            r_cnt <= '0;
            r_acc <= '0;
        end else if (w_accept) begin
            r_cnt <= r_cnt + c_ONE;
            r_acc <= w_acc_shift;
        end
    end

    // Two-entry circular output buffer with occupancy counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem[0]  <= '0;
            r_mem[1]  <= '0;
            r_part[0] <= 1'b0;
            r_part[1] <= 1'b0;
`ifdef SHIFT_ASM_PARITY_EN
            r_par[0]  <= 1'b0;
            r_par[1]  <= 1'b0;
`endif
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_fill    <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wptr]  <= w_push_word;
                r_part[r_wptr] <= w_flush;
`ifdef SHIFT_ASM_PARITY_EN
                r_par[r_wptr]  <= ^w_push_word;
`endif
                r_wptr         <= ~r_wptr;
            end
            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_fill <= r_fill + 2'd1;
                2'b01:   r_fill <= r_fill - 2'd1;
                default: r_fill <= r_fill;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_shift_word_assembler.sv
`default_nettype none
// ============================================================================
// Module      : tb_shift_word_assembler
// Description : Directed self-checking bench for shift_word_assembler. Two
//               instances (MSB-first and LSB-first) share one stimulus stream.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_shift_word_assembler;

    logic       clk;
    logic       rst;
    logic       bit_in;
    logic       bit_valid;
    logic       flush;
    logic       word_ready;

    logic       m_bit_ready, m_word_partial, m_word_valid;
    logic [3:0] m_word_out;
    logic [1:0] m_fill;
    logic       l_bit_ready, l_word_partial, l_word_valid;
    logic [3:0] l_word_out;
    logic [1:0] l_fill;
`ifdef SHIFT_ASM_PARITY_EN
    logic       m_word_par;
    logic       l_word_par;
`endif

    int n_cmp;
    int n_err;

    shift_word_assembler #(.WIDTH(4), .MSB_FIRST(1)) dut_m (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (m_bit_ready),
        .flush        (flush),
        .word_out     (m_word_out),
        .word_partial (m_word_partial),
        .word_valid   (m_word_valid),
        .word_ready   (word_ready),
        .fill_level   (m_fill)
`ifdef SHIFT_ASM_PARITY_EN
        ,
        .word_par     (m_word_par)
`endif
    );

    shift_word_assembler #(.WIDTH(4), .MSB_FIRST(0)) dut_l (
        .clk          (clk),
        .rst          (rst),
        .bit_in       (bit_in),
        .bit_valid    (bit_valid),
        .bit_ready    (l_bit_ready),
        .flush        (flush),
        .word_out     (l_word_out),
        .word_partial (l_word_partial),
        .word_valid   (l_word_valid),
        .word_ready   (word_ready),
        .fill_level   (l_fill)
`ifdef SHIFT_ASM_PARITY_EN
        ,
        .word_par     (l_word_par)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic b);
        bit_in    = b;
        bit_valid = 1'b1;
        tick();
        bit_valid = 1'b0;
    endtask

    initial begin
        n_cmp      = 0;
        n_err      = 0;
        rst        = 1'b0;
        bit_in     = 1'b0;
        bit_valid  = 1'b0;
        flush      = 1'b0;
        word_ready = 1'b1;
        tick();
        tick();

        // Reset state
        chk("rst_valid",  {31'd0, m_word_valid}, 32'd0);
        chk("rst_fill",   {30'd0, m_fill},       32'd0);
        chk("rst_ready",  {31'd0, m_bit_ready},  32'd0);
        chk("rst_word",   {28'd0, m_word_out},   32'd0);
        rst = 1'b1;
        #1;
        chk("rel_ready",  {31'd0, m_bit_ready},  32'd1);

        // Full word 1,0,1,1
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        chk("w1_valid",   {31'd0, m_word_valid},   32'd1);
        chk("w1_msb",     {28'd0, m_word_out},     32'hB);
        chk("w1_part",    {31'd0, m_word_partial}, 32'd0);
        chk("w1_lsb",     {28'd0, l_word_out},     32'hD);
        chk("w1_fill",    {30'd0, m_fill},         32'd1);
`ifdef SHIFT_ASM_PARITY_EN
        chk("w1_par",     {31'd0, m_word_par},     32'd1);
`endif
        tick();
        chk("w1_pop",     {31'd0, m_word_valid},   32'd0);
        chk("w1_empty0",  {28'd0, m_word_out},     32'd0);

        // Backpressure: 1111, 0000 buffered, then 1010 after draining
        word_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b0);
        chk("bp_fill2",   {30'd0, m_fill},       32'd2);
        chk("bp_notrdy",  {31'd0, m_bit_ready},  32'd0);
        chk("bp_head",    {28'd0, m_word_out},   32'hF);
        bit_in    = 1'b1;
        bit_valid = 1'b1;
        tick();
        chk("bp_hold",    {30'd0, m_fill},       32'd2);
        chk("bp_stable",  {28'd0, m_word_out},   32'hF);
        word_ready = 1'b1;
        tick();
        chk("bp_pop1",    {28'd0, m_word_out},   32'h0);
        chk("bp_fill1",   {30'd0, m_fill},       32'd1);
        tick();
        chk("bp_fill0",   {30'd0, m_fill},       32'd0);
        bit_in = 1'b0; tick();
        bit_in = 1'b1; tick();
        bit_in = 1'b0; tick();
        bit_valid = 1'b0;
        chk("bp_third",   {28'd0, m_word_out},   32'hA);
        chk("bp_valid3",  {31'd0, m_word_valid}, 32'd1);
        tick();

        // Flush after two bits
        send_bit(1'b1); send_bit(1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_msb",     {28'd0, m_word_out},     32'hC);
        chk("fl_part",    {31'd0, m_word_partial}, 32'd1);
        chk("fl_lsb",     {28'd0, l_word_out},     32'h3);
`ifdef SHIFT_ASM_PARITY_EN
        chk("fl_par",     {31'd0, m_word_par},     32'd0);
`endif
        tick();
        // Flush with nothing held
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_empty",   {31'd0, m_word_valid},   32'd0);
        chk("fl_empty_f", {30'd0, m_fill},         32'd0);

        // Flush together with the 3rd bit: n=3, padded
        send_bit(1'b1); send_bit(1'b0);
        bit_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
        tick();
        bit_valid = 1'b0; flush = 1'b0;
        chk("fl3_msb",    {28'd0, m_word_out},     32'hA);
        chk("fl3_lsb",    {28'd0, l_word_out},     32'h5);
        chk("fl3_part",   {31'd0, m_word_partial}, 32'd1);
        tick();

        // Flush together with the 4th bit: normal full word
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        bit_in = 1'b1; bit_valid = 1'b1; flush = 1'b1;
        tick();
        bit_valid = 1'b0; flush = 1'b0;
        chk("fl4_msb",    {28'd0, m_word_out},     32'hB);
        chk("fl4_part",   {31'd0, m_word_partial}, 32'd0);
        tick();

        // Reset mid-word with a buffered word
        word_ready = 1'b0;
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        chk("mr_pre",     {31'd0, m_word_valid},   32'd1);
        rst = 1'b0;
        #1;
        chk("mr_valid",   {31'd0, m_word_valid},   32'd0);
        chk("mr_word",    {28'd0, m_word_out},     32'd0);
        chk("mr_fill",    {30'd0, m_fill},         32'd0);
        chk("mr_ready",   {31'd0, m_bit_ready},    32'd0);
        tick();
        rst = 1'b1;
        word_ready = 1'b1;
        #1;
        send_bit(1'b0); send_bit(1'b0); send_bit(1'b0); send_bit(1'b1);
        chk("mr_msb",     {28'd0, m_word_out},     32'h1);
        chk("mr_lsb",     {28'd0, l_word_out},     32'h8);
        chk("mr_part",    {31'd0, m_word_partial}, 32'd0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
